engine_scheduler: RTL and testbench
===================================

ENGINE_SCHEDULER -- requirements
Module: engine_scheduler

Interface
REQ-001 Parameter NUM_ENGINES, 6, number of mandelbrot engines scheduled.
REQ-002 Parameter DATA_WIDTH, 32, pixel coordinate width.
REQ-003 Parameter X_SIZE, 640, pixels per line.
REQ-004 Parameter Y_SIZE, 480, lines per frame.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  single-cycle request to render one frame.
REQ-008 eng_idle  in  NUM_ENGINES  engine i can accept a new pixel.
REQ-009 queue_full  in  NUM_ENGINES  output queue i cannot accept a result.
REQ-010 eng_done  in  NUM_ENGINES  engine i result written to its queue (1-cycle pulse).
REQ-011 eng_start  out  NUM_ENGINES  one-hot load pulse to engine i.
REQ-012 px_x, px_y  out  DATA_WIDTH each  pixel coordinates, valid only in the eng_start cycle.
REQ-013 busy  out  1  frame in progress.
REQ-014 frame_done  out  1  single-cycle pulse when the last pixel retires.
REQ-015 outstanding  out  $clog2(NUM_ENGINES+1)  count of dispatched, unretired pixels.

Function
REQ-016 FSM states IDLE, DISPATCH, DRAIN, DONE; IDLE after reset.
REQ-017 IDLE->DISPATCH on start; px counters cleared to (0,0) that cycle; start ignored in all other states.
REQ-018 Engine i eligible when eng_idle[i] & ~queue_full[i] & ~pending[i].
REQ-019 In DISPATCH, at most one grant per cycle, round-robin: search starts at engine (last_grant+1) mod NUM_ENGINES; first eligible wins; pointer starts at engine 0 after reset.
REQ-020 eng_start registered: asserted the cycle after the grant decision, with px_x/px_y of the granted pixel; one-cycle latency from eligibility to eng_start.
REQ-021 On grant: pending[i] set, coordinates advance raster order, px_x increments, at X_SIZE-1 wraps to 0 and px_y increments.
REQ-022 After granting (X_SIZE-1, Y_SIZE-1): DISPATCH->DRAIN, no further grants.
REQ-023 eng_done[i] clears pending[i]; eng_done on a non-pending engine ignored.
REQ-024 Grant and done for different engines in the same cycle both take effect; outstanding changes by net (+1-1=0).
REQ-025 outstanding equals popcount(pending) at all times; never exceeds NUM_ENGINES.
REQ-026 DRAIN->DONE when outstanding==0; DONE asserts frame_done for one cycle then ->IDLE.
REQ-027 busy high in DISPATCH and DRAIN, low in IDLE and DONE.
REQ-028 No eligible engine: no grant, counters hold, no eng_start.
REQ-029 Coordinate counters use DATA_WIDTH; X_SIZE, Y_SIZE >= 1; X_SIZE=1 wraps every grant.

Reset
REQ-030 Reset synchronous, active-high, priority over all other inputs, including mid-frame.
REQ-031 Reset values: state IDLE, eng_start 0, px_x 0, px_y 0, busy 0, frame_done 0, outstanding 0, pending 0, round-robin pointer 0.
REQ-032 eng_done arriving the cycle after reset is ignored (pending already 0).

Structure
REQ-033 Shared package mandelbrot_pkg holds NUM_ENGINES, DATA_WIDTH, X_SIZE, Y_SIZE defaults and the sched_state_t enum.
REQ-034 One sub-module rr_arbiter (request vector, pointer in; one-hot grant, valid out; combinational); FSM, counters, pending register stay in engine_scheduler.

Verification
REQ-035 X_SIZE=4, Y_SIZE=2, NUM_ENGINES=2, all idle, done returned 3 cycles after each start -> 8 eng_start pulses alternating engines 0,1, coordinates (0,0)..(3,1) raster order, exactly one frame_done after last done, busy low afterwards.
REQ-036 queue_full[0]=1 for whole frame -> all 8 pixels dispatched to engine 1 only; outstanding never exceeds 1.
REQ-037 start pulse while busy -> ignored; pixel sequence and frame_done count unchanged (1).
REQ-038 Same-cycle eng_done[0] and grant to engine 1 -> outstanding stays at 1; both pending bits updated correctly.
REQ-039 reset asserted after 3 grants -> next cycle all outputs at reset values; subsequent start restarts at (0,0) granting engine 0.
REQ-040 Spurious eng_done[1] while pending[1]=0 -> outstanding unchanged, no premature frame_done.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the mandelbrot rendering pipeline.
package mandelbrot_pkg;

   // Default frame geometry and engine count.
   localparam int NUM_ENGINES = 6;
   localparam int DATA_WIDTH  = 32;
   localparam int X_SIZE      = 640;
   localparam int Y_SIZE      = 480;

   // Frame scheduler phases.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      DONE     = 2'd3
   } sched_state_t;

   // Width of an index into n engines; never collapses to zero bits.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/engine_scheduler_if.sv
// Scheduler-facing bundle: frame request, per-engine status, dispatch and
// frame progress. master = scheduler side, slave = host/engine side.
interface engine_scheduler_if #(
   parameter int NUM_ENGINES = mandelbrot_pkg::NUM_ENGINES,
   parameter int DATA_WIDTH  = mandelbrot_pkg::DATA_WIDTH
);

   localparam int OUT_W = $clog2(NUM_ENGINES + 1);

   logic                   start;
   logic [NUM_ENGINES-1:0] eng_idle;
   logic [NUM_ENGINES-1:0] queue_full;
   logic [NUM_ENGINES-1:0] eng_done;
   logic [NUM_ENGINES-1:0] eng_start;
   logic [DATA_WIDTH-1:0]  px_x;
   logic [DATA_WIDTH-1:0]  px_y;
   logic                   busy;
   logic                   frame_done;
   logic [OUT_W-1:0]       outstanding;

   modport master (
      input  start, eng_idle, queue_full, eng_done,
      output eng_start, px_x, px_y, busy, frame_done, outstanding
   );

   modport slave (
      output start, eng_idle, queue_full, eng_done,
      input  eng_start, px_x, px_y, busy, frame_done, outstanding
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at ptr_i and wraps,
// the first requester found wins. Grant is one-hot, valid_o flags any grant.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic             valid_o
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] gnt_dbl;
   logic [N-1:0]   req_rot;
   logic [N-1:0]   gnt_rot;

   // Rotate so ptr_i sits at bit 0, pick the lowest set bit, rotate back.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      req_dbl = {req_i, req_i} >> ptr_i;
      req_rot = req_dbl[N-1:0];
      gnt_rot = '0;
      valid_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (req_rot[k] && !valid_o) begin
            gnt_rot[k] = 1'b1;
            valid_o    = 1'b1;
         end
      end
      gnt_dbl = {gnt_rot, gnt_rot} << ptr_i;
      grant_o = gnt_dbl[2*N-1:N];
   end

endmodule

// File: rtl/engine_scheduler.sv
// Frame scheduler: walks the pixel raster and hands one pixel per cycle to
// an eligible engine in round-robin order, tracks in-flight pixels per
// engine and reports frame completion once every dispatched pixel retired.
module engine_scheduler #(
   parameter int NUM_ENGINES = mandelbrot_pkg::NUM_ENGINES,
   parameter int DATA_WIDTH  = mandelbrot_pkg::DATA_WIDTH,
   parameter int X_SIZE      = mandelbrot_pkg::X_SIZE,
   parameter int Y_SIZE      = mandelbrot_pkg::Y_SIZE
) (
   input logic                clk,
   input logic                reset,
   engine_scheduler_if.master bus
);

   localparam int PTR_W = mandelbrot_pkg::ptr_width(NUM_ENGINES);
   localparam int CNT_W = $clog2(NUM_ENGINES + 1);

   localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_SIZE - 1);
   localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_SIZE - 1);
   localparam logic [PTR_W-1:0]      P_LAST = PTR_W'(NUM_ENGINES - 1);

   mandelbrot_pkg::sched_state_t state_q, state_d;

   logic [DATA_WIDTH-1:0]  px_x_q, px_x_d;       // next pixel to hand out
   logic [DATA_WIDTH-1:0]  px_y_q, px_y_d;
   logic [NUM_ENGINES-1:0] pending_q, pending_d; // engine holds an unretired pixel
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;   // first engine of the next search
   logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
   logic [DATA_WIDTH-1:0]  out_x_q, out_x_d;     // coordinates shown with eng_start
   logic [DATA_WIDTH-1:0]  out_y_q, out_y_d;

   logic [NUM_ENGINES-1:0] eligible;
   logic [NUM_ENGINES-1:0] request;
   logic [NUM_ENGINES-1:0] grant;
   logic                   grant_valid;
   logic [PTR_W-1:0]       grant_idx;
   logic [CNT_W-1:0]       outstanding;

   // An engine may take a pixel when it is idle, its result queue has room
   // and it is not still working on an earlier pixel of ours.
   assign eligible = bus.eng_idle & ~bus.queue_full & ~pending_q;
   assign request  = (state_q == mandelbrot_pkg::DISPATCH) ? eligible : '0;

   rr_arbiter #(
      .N     (NUM_ENGINES),
      .PTR_W (PTR_W)
   ) u_arb (
      .req_i   (request),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .valid_o (grant_valid)
   );

   // Convert the one-hot grant into an engine index for the pointer update.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   // In-flight pixel count is the population of the pending vector.
   always_comb begin
      outstanding = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         outstanding = outstanding + CNT_W'(pending_q[i]);
      end
   end

   // Next-state logic: frame phases, raster walk, pending bookkeeping.
   always_comb begin
      state_d     = state_q;
      px_x_d      = px_x_q;
      px_y_d      = px_y_q;
      rr_ptr_d    = rr_ptr_q;
      eng_start_d = '0;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      // Retirements always apply; a done on a non-pending engine clears
      // nothing. A grant below ORs in afterwards, so a same-cycle grant and
      // done on different engines both land.
      pending_d   = pending_q & ~bus.eng_done;

      unique case (state_q)
         mandelbrot_pkg::IDLE: begin
            if (bus.start) begin
               state_d = mandelbrot_pkg::DISPATCH;
               px_x_d  = '0;
               px_y_d  = '0;
            end
         end

         mandelbrot_pkg::DISPATCH: begin
            if (grant_valid) begin
               pending_d   = pending_d | grant;
               eng_start_d = grant;
               out_x_d     = px_x_q;
               out_y_d     = px_y_q;
               rr_ptr_d    = (grant_idx == P_LAST) ? '0 : grant_idx + PTR_W'(1);
               if (px_x_q == X_LAST) begin
                  px_x_d = '0;
                  if (px_y_q == Y_LAST) begin
                     // Last pixel of the frame is out; wait for retirements.
                     state_d = mandelbrot_pkg::DRAIN;
                  end else begin
                     px_y_d = px_y_q + DATA_WIDTH'(1);
                  end
               end else begin
                  px_x_d = px_x_q + DATA_WIDTH'(1);
               end
            end
         end

         mandelbrot_pkg::DRAIN: begin
            if (outstanding == '0) state_d = mandelbrot_pkg::DONE;
         end

         mandelbrot_pkg::DONE: begin
            state_d = mandelbrot_pkg::IDLE;
         end

         default: begin
            state_d = mandelbrot_pkg::IDLE;
         end
      endcase
   end

   // State registers; reset wins over every other input, even mid-frame.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge value of its neighbours, independent of statement order.
      if (reset) begin
         state_q     <= mandelbrot_pkg::IDLE;
         px_x_q      <= '0;
         px_y_q      <= '0;
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         eng_start_q <= '0;
         out_x_q     <= '0;
         out_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         px_x_q      <= px_x_d;
         px_y_q      <= px_y_d;
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         eng_start_q <= eng_start_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
      end
   end

   assign bus.eng_start   = eng_start_q;
   assign bus.px_x        = out_x_q;
   assign bus.px_y        = out_y_q;
   assign bus.busy        = (state_q == mandelbrot_pkg::DISPATCH) ||
                            (state_q == mandelbrot_pkg::DRAIN);
   assign bus.frame_done  = (state_q == mandelbrot_pkg::DONE);
   assign bus.outstanding = outstanding;

endmodule

// File: tb/tb_engine_scheduler.sv
// Bench for engine_scheduler: engine models answer each dispatch after a
// delay, a reference model predicts dispatches and frame progress, and a
// monitor compares DUT outputs against those predictions every cycle.
module tb_engine_scheduler;

   localparam int N    = 2;
   localparam int DW   = 32;
   localparam int XS   = 4;
   localparam int YS   = 2;
   localparam int NPIX = XS * YS;

   logic clk;
   logic reset;

   engine_scheduler_if #(.NUM_ENGINES(N), .DATA_WIDTH(DW)) bus ();

   engine_scheduler #(
      .NUM_ENGINES (N),
      .DATA_WIDTH  (DW),
      .X_SIZE      (XS),
      .Y_SIZE      (YS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- checks
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------- stimulus knobs
   bit         mon_en      = 1'b0;
   bit         start_req   = 1'b0;
   bit         noise_start = 1'b0;
   bit         rand_avail  = 1'b0;
   bit         rand_delay  = 1'b0;
   bit         spur_en     = 1'b0;
   logic [N-1:0] qf_fixed  = '0;
   int         delay [N]   = '{3, 3};

   // ------------------------------------------------ engines and host driver
   int         eng_cnt [N];
   logic [N-1:0] dv;

   initial begin
      bus.start      = 1'b0;
      bus.eng_idle   = '1;
      bus.queue_full = '0;
      bus.eng_done   = '0;
      for (int i = 0; i < N; i++) eng_cnt[i] = 0;
      forever begin
         @(negedge clk);
         #1;
         dv = '0;
         for (int i = 0; i < N; i++) begin
            if (eng_cnt[i] > 0) begin
               eng_cnt[i]--;
               if (eng_cnt[i] == 0) dv[i] = 1'b1;
            end
            if (bus.eng_start[i] === 1'b1)
               eng_cnt[i] = rand_delay ? int'($urandom_range(1, 5)) : delay[i];
            if (spur_en && eng_cnt[i] == 0 && !dv[i] && $urandom_range(0, 5) == 0)
               dv[i] = 1'b1;
         end
         bus.eng_done = dv;
         bus.start    = start_req || (noise_start && bus.busy === 1'b1 &&
                                      $urandom_range(0, 2) == 0);
         start_req    = 1'b0;
         if (rand_avail) begin
            for (int i = 0; i < N; i++) begin
               bus.eng_idle[i]   = ($urandom_range(0, 4) != 0);
               bus.queue_full[i] = ($urandom_range(0, 4) == 0);
            end
         end else begin
            bus.eng_idle   = '1;
            bus.queue_full = qf_fixed;
         end
      end
   end

   // -------------------------------------------------------- reference model
   // Phases: 0 idle, 1 handing out pixels, 2 waiting for retirements,
   // 3 frame-done cycle. Pixel k of the frame is (k % XS, k / XS).
   typedef struct {
      int eng;
      int x;
      int y;
   } exp_t;

   exp_t         exp_q [$];
   int           m_phase = 0;
   logic [N-1:0] m_pend  = '0;
   logic [N-1:0] m_old;
   int           m_ptr   = 0;
   int           m_next  = 0;
   int           m_g;
   int           m_e;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_phase = 0;
            m_pend  = '0;
            m_ptr   = 0;
            m_next  = 0;
         end else begin
            m_old = m_pend;
            m_g   = -1;
            if (m_phase == 1) begin
               for (int k = 0; k < N; k++) begin
                  m_e = (m_ptr + k) % N;
                  if (m_g < 0 && bus.eng_idle[m_e] && !bus.queue_full[m_e] && !m_pend[m_e])
                     m_g = m_e;
               end
            end
            m_pend = m_pend & ~bus.eng_done;
            case (m_phase)
               0: if (bus.start) begin
                     m_phase = 1;
                     m_next  = 0;
                  end
               1: if (m_g >= 0) begin
                     m_pend[m_g] = 1'b1;
                     exp_q.push_back('{eng: m_g, x: m_next % XS, y: m_next / XS});
                     m_ptr  = (m_g + 1) % N;
                     m_next = m_next + 1;
                     if (m_next == NPIX) m_phase = 2;
                  end
               2: if (m_old == '0) m_phase = 3;
               default: m_phase = 0;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   int           starts;
   int           per_eng [N];
   int           fd_cnt;
   int           max_out;
   logic [N-1:0] first_vec;
   logic [DW-1:0] first_x;
   logic [DW-1:0] first_y;
   exp_t         mon_e;
   logic [N-1:0] mon_oh;

   task automatic clear_stats();
      starts  = 0;
      fd_cnt  = 0;
      max_out = 0;
      for (int i = 0; i < N; i++) per_eng[i] = 0;
   endtask

   initial begin
      clear_stats();
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.eng_start !== '0) begin
               starts++;
               for (int i = 0; i < N; i++) if (bus.eng_start[i] === 1'b1) per_eng[i]++;
               if (starts == 1) begin
                  first_vec = bus.eng_start;
                  first_x   = bus.px_x;
                  first_y   = bus.px_y;
               end
               if (exp_q.size() == 0) begin
                  check("unexpected_eng_start", bus.eng_start, 0);
               end else begin
                  mon_e  = exp_q.pop_front();
                  mon_oh = '0;
                  mon_oh[mon_e.eng] = 1'b1;
                  check("eng_start_onehot", bus.eng_start, mon_oh);
                  check("px_x", bus.px_x, mon_e.x);
                  check("px_y", bus.px_y, mon_e.y);
               end
            end else if (exp_q.size() != 0) begin
               mon_e  = exp_q.pop_front();
               mon_oh = '0;
               mon_oh[mon_e.eng] = 1'b1;
               check("missing_eng_start", bus.eng_start, mon_oh);
            end
            check("busy", bus.busy, (m_phase == 1 || m_phase == 2));
            check("frame_done", bus.frame_done, (m_phase == 3));
            check("outstanding", bus.outstanding, $countones(m_pend));
            if (bus.frame_done === 1'b1) fd_cnt++;
            if (int'(bus.outstanding) > max_out) max_out = int'(bus.outstanding);
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic run_frame(input string name);
      bit seen;
      clear_stats();
      @(negedge clk);
      start_req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 600 && !seen; c++) begin
         @(negedge clk);
         if (bus.frame_done === 1'b1) seen = 1'b1;
      end
      check({name, "_frame_done_seen"}, seen, 1);
      repeat (4) @(negedge clk);
      check({name, "_start_pulses"}, starts, NPIX);
      check({name, "_frame_done_count"}, fd_cnt, 1);
      check({name, "_busy_after"}, bus.busy, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_eng_start"}, bus.eng_start, 0);
      check({name, "_px_x"}, bus.px_x, 0);
      check({name, "_px_y"}, bus.px_y, 0);
      check({name, "_busy"}, bus.busy, 0);
      check({name, "_frame_done"}, bus.frame_done, 0);
      check({name, "_outstanding"}, bus.outstanding, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------- main flow
   initial begin
      bit reached;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Plain frame: engines alternate 0,1 in raster order.
      run_frame("basic");
      check("basic_eng0_pulses", per_eng[0], NPIX / 2);
      check("basic_eng1_pulses", per_eng[1], NPIX / 2);

      // Engine 0 queue permanently full: everything goes to engine 1.
      qf_fixed = 2'b01;
      run_frame("qfull0");
      check("qfull0_eng0_pulses", per_eng[0], 0);
      check("qfull0_eng1_pulses", per_eng[1], NPIX);
      check("qfull0_max_out_le1", (max_out <= 1), 1);
      qf_fixed = '0;

      // Extra start pulses while busy must not disturb the frame.
      noise_start = 1'b1;
      run_frame("start_noise");
      noise_start = 1'b0;

      // Uneven latencies put a retirement and a new grant in the same cycle.
      delay = '{3, 1};
      run_frame("same_cycle");
      check("same_cycle_max_out", (max_out <= N), 1);
      delay = '{3, 3};

      // Reset in the middle of a frame, then restart from scratch.
      clear_stats();
      @(negedge clk);
      start_req = 1'b1;
      reached = 1'b0;
      for (int c = 0; c < 200 && !reached; c++) begin
         @(posedge clk);
         if (starts >= 3) reached = 1'b1;
      end
      check("midreset_three_grants_seen", reached, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_frame("restart");
      check("restart_first_engine", first_vec, 1);
      check("restart_first_x", first_x, 0);
      check("restart_first_y", first_y, 0);

      // Random availability, latencies and spurious retirements.
      rand_avail = 1'b1;
      rand_delay = 1'b1;
      spur_en    = 1'b1;
      for (int f = 0; f < 4; f++) run_frame($sformatf("random%0d", f));
      rand_avail = 1'b0;
      rand_delay = 1'b0;
      spur_en    = 1'b0;
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
